// File: rtl/aer_rate_encoder_if.sv
// Bus bundle for the AER rate encoder: sample control, pixel-buffer read port,
// AER output handshake and status.
interface aer_rate_encoder_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned PIX_W  = 10
);
    logic              START;
    logic [15:0]       SEED;
    logic [PIX_W-1:0]  PIX_ADDR;
    logic [7:0]        PIX_DATA;
    logic [ADDR_W-1:0] AERIN_ADDR;
    logic              AERIN_REQ;
    logic              AERIN_ACK;
    logic              BUSY;
    logic [7:0]        STEP_IDX;
    logic              DONE;

    modport master (
        input  START, SEED, PIX_DATA, AERIN_ACK,
        output PIX_ADDR, AERIN_ADDR, AERIN_REQ, BUSY, STEP_IDX, DONE
    );

    modport slave (
        output START, SEED, PIX_DATA, AERIN_ACK,
        input  PIX_ADDR, AERIN_ADDR, AERIN_REQ, BUSY, STEP_IDX, DONE
    );
endinterface

// File: rtl/aer_rate_encoder.sv
// Rate-coding spike source: compares every pixel against an LFSR byte once per time step
// and emits each spike as a 4-phase AER event, closing every pass with a marker event.
module aer_rate_encoder #(
    parameter int unsigned        N         = 784,
    parameter int unsigned        STEPS     = 8,
    parameter int unsigned        ADDR_W    = 12,
    parameter int unsigned        PIX_W     = 10,
    parameter logic [ADDR_W-1:0]  TICK_ADDR = {ADDR_W{1'b1}}
) (
    input  logic               CLK,
    input  logic               RST,
    aer_rate_encoder_if.master bus
);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(N - 1);
    localparam logic [7:0]       LAST_STEP = 8'(STEPS - 1);
    localparam logic [15:0]      SEED_DFLT = 16'hACE1;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_REQ_HI,
        S_REQ_LO,
        S_TICK_HI,
        S_TICK_LO,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d, lfsr_step;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [7:0]        step_q, step_d;
    logic [ADDR_W-1:0] aer_addr_q, aer_addr_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              spike;
    logic              next_pix;

    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign spike     = (bus.PIX_DATA == 8'hFF) || (bus.PIX_DATA > lfsr_q[7:0]);

    // The pixel index register doubles as the registered read address.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        pix_d      = pix_q;
        step_d     = step_q;
        aer_addr_d = aer_addr_q;
        req_d      = req_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        next_pix   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    lfsr_d  = (bus.SEED == 16'h0000) ? SEED_DFLT : bus.SEED;
                    pix_d   = '0;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_CMP;
            S_CMP: begin
                lfsr_d = lfsr_step;
                if (spike) begin
                    aer_addr_d = ADDR_W'(pix_q);
                    req_d      = 1'b1;
                    state_d    = S_REQ_HI;
                end else begin
                    next_pix = 1'b1;
                end
            end
            S_REQ_HI: begin
                if (bus.AERIN_ACK) begin
                    req_d   = 1'b0;
                    state_d = S_REQ_LO;
                end
            end
            S_REQ_LO: begin
                if (!bus.AERIN_ACK) begin
                    next_pix = 1'b1;
                end
            end
            S_TICK_HI: begin
                if (bus.AERIN_ACK) begin
                    req_d   = 1'b0;
                    state_d = S_TICK_LO;
                end
            end
            S_TICK_LO: begin
                if (!bus.AERIN_ACK) begin
                    if (step_q < LAST_STEP) begin
                        step_d  = step_q + 8'd1;
                        state_d = S_READ;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Shared by the non-spiking CMP exit and the REQ_LO exit.
        if (next_pix) begin
            if (pix_q < LAST_PIX) begin
                pix_d   = pix_q + 1'b1;
                state_d = S_READ;
            end else begin
                pix_d      = '0;
                aer_addr_d = TICK_ADDR;
                req_d      = 1'b1;
                state_d    = S_TICK_HI;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED_DFLT;
            pix_q      <= '0;
            step_q     <= '0;
            aer_addr_q <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            pix_q      <= pix_d;
            step_q     <= step_d;
            aer_addr_q <= aer_addr_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.PIX_ADDR   = pix_q;
    assign bus.AERIN_ADDR = aer_addr_q;
    assign bus.AERIN_REQ  = req_q;
    assign bus.BUSY       = busy_q;
    assign bus.STEP_IDX   = step_q;
    assign bus.DONE       = done_q;
endmodule
